// File: rtl/sm_control_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sm_control_debounce_pkg
//  Description : Shared definitions for the sm_* control conditioning path:
//                2-bit debounce FSM state encodings and the default
//                debounce/synchronizer depths used across sm_* blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package sm_control_debounce_pkg;

    // Debounce FSM encodings. All four codes are in use.
    localparam logic [1:0] STABLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH   = 2'd1;
    localparam logic [1:0] STABLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW    = 2'd3;

    // Defaults shared by every sm_* instance and bench.
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int GLITCH_W_DEF        = 8;

endpackage
`default_nettype wire

// File: rtl/sm_control_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module      : sm_control_debounce_if
//  Description : Signal bundle between the raw control pin and the
//                debounced control outputs.
//                  raw_in       : asynchronous raw input (pin side)
//                  control      : debounced level
//                  control_rise : one-cycle strobe on 0->1 of control
//                  control_fall : one-cycle strobe on 1->0 of control
//                  glitch_cnt   : saturating count of aborted level changes
//                master = pin/consumer side, slave = debouncer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sm_control_debounce_if #(
    parameter int GLITCH_W = 8
) ();
    logic                raw_in;
    logic                control;
    logic                control_rise;
    logic                control_fall;
    logic [GLITCH_W-1:0] glitch_cnt;

    modport master (
        output raw_in,
        input  control,
        input  control_rise,
        input  control_fall,
        input  glitch_cnt
    );

    modport slave (
        input  raw_in,
        output control,
        output control_rise,
        output control_fall,
        output glitch_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sm_control_debounce_sync.sv
`default_nettype none
// ============================================================================
//  Module      : sm_sync
//  Description : Reset-to-0 flop chain that brings an asynchronous input
//                into the clk domain.
//                  clk   : system clock
//                  reset : synchronous active-high reset
//                  d     : asynchronous input
//                  q     : synchronized output (last stage)
//  Revision    : 1.0 - initial release
// ============================================================================
module sm_sync #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic d,
    output logic      q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/sm_control_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sm_control_debounce
//  Description : Synchronizes and debounces a raw control pin. A new level
//                is accepted after DEBOUNCE_CYCLES consecutive synchronized
//                samples; shorter excursions are counted as glitches.
//                  clk   : system clock
//                  reset : synchronous active-high reset
//                  bus   : slave side of sm_control_debounce_if
//                          (raw_in in; control, strobes, glitch_cnt out)
//  Revision    : 1.0 - initial release
// ============================================================================
module sm_control_debounce
    import sm_control_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int GLITCH_W        = GLITCH_W_DEF
) (
    input  wire logic            clk,
    input  wire logic            reset,
    sm_control_debounce_if.slave bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // The sample that enters WAIT_* already counts as the first, so the
    // level is accepted when the count shows DEBOUNCE_CYCLES-1 earlier hits.
    localparam logic [CNT_W-1:0]    c_cnt_last  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_cnt_one   = CNT_W'(1);
    localparam logic [GLITCH_W-1:0] c_glitch_max = '1;

    logic                w_s;
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_control;
    logic                w_control_nxt;
    logic                r_rise;
    logic                w_rise_nxt;
    logic                r_fall;
    logic                w_fall_nxt;
    logic [GLITCH_W-1:0] r_glitch;
    logic                w_glitch_inc;

    sm_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.raw_in),
        .q     (w_s)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= STABLE_LOW;
            r_cnt     <= '0;
            r_control <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_glitch  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_control <= w_control_nxt;
            r_rise    <= w_rise_nxt;
            r_fall    <= w_fall_nxt;
            if (w_glitch_inc && (r_glitch != c_glitch_max)) begin
                r_glitch <= r_glitch + GLITCH_W'(1);
            end
        end
    end

    // Next-state
    always_comb begin
        w_state_nxt = STABLE_LOW;
        case (r_state)
            STABLE_LOW:  w_state_nxt = w_s ? WAIT_HIGH : STABLE_LOW;
            WAIT_HIGH: begin
                if (!w_s)                     w_state_nxt = STABLE_LOW;
                else if (r_cnt == c_cnt_last) w_state_nxt = STABLE_HIGH;
                else                          w_state_nxt = WAIT_HIGH;
            end
            STABLE_HIGH: w_state_nxt = w_s ? STABLE_HIGH : WAIT_LOW;
            WAIT_LOW: begin
                if (w_s)                      w_state_nxt = STABLE_HIGH;
                else if (r_cnt == c_cnt_last) w_state_nxt = STABLE_LOW;
                else                          w_state_nxt = WAIT_LOW;
            end
            default:     w_state_nxt = STABLE_LOW;
        endcase
    end

    // Output / datapath next values. The counter defaults to zero so it is
    // cleared on every state entry except the explicit WAIT_* entries.
    always_comb begin
        w_cnt_nxt     = '0;
        w_control_nxt = 1'b0;
        w_rise_nxt    = 1'b0;
        w_fall_nxt    = 1'b0;
        w_glitch_inc  = 1'b0;
        case (r_state)
            STABLE_LOW: begin
                w_control_nxt = 1'b0;
                if (w_s) w_cnt_nxt = c_cnt_one;
            end
            WAIT_HIGH: begin
                w_control_nxt = 1'b0;
                if (!w_s) begin
                    w_glitch_inc = 1'b1;
                end else if (r_cnt == c_cnt_last) begin
                    w_control_nxt = 1'b1;
                    w_rise_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            STABLE_HIGH: begin
                w_control_nxt = 1'b1;
                if (!w_s) w_cnt_nxt = c_cnt_one;
            end
            WAIT_LOW: begin
                w_control_nxt = 1'b1;
                if (w_s) begin
                    w_glitch_inc = 1'b1;
                end else if (r_cnt == c_cnt_last) begin
                    w_control_nxt = 1'b0;
                    w_fall_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_control_nxt = 1'b0;
            end
        endcase
    end

    assign bus.control      = r_control;
    assign bus.control_rise = r_rise;
    assign bus.control_fall = r_fall;
    assign bus.glitch_cnt   = r_glitch;

endmodule
`default_nettype wire

// File: tb/tb_sm_control_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm_control_debounce
//  Description : Directed self-checking bench for sm_control_debounce.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_control_debounce;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    sm_control_debounce_if #(.GLITCH_W(8)) bus ();

    sm_control_debounce #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2),
        .GLITCH_W        (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One active edge; outputs are sampled 1 time unit after it and new
    // inputs applied there, i.e. before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.raw_in = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.control !== 1'b0 || bus.control_rise !== 1'b0 || bus.control_fall !== 1'b0
            || bus.glitch_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_hold: ctl=%b rise=%b fall=%b glitch=%0d required 0/0/0/0",
                     bus.control, bus.control_rise, bus.control_fall, bus.glitch_cnt);
        end
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (bus.control !== 1'b0 || bus.control_rise !== 1'b0 || bus.control_fall !== 1'b0
                || bus.glitch_cnt !== 8'd0) begin
                failures++;
                $display("FAIL reset_idle[%0d]: ctl=%b rise=%b fall=%b glitch=%0d required 0/0/0/0",
                         i, bus.control, bus.control_rise, bus.control_fall, bus.glitch_cnt);
            end
        end
    endtask

    // raw_in rises before edge k (i=1); control must change at edge k+5 (i=6).
    task automatic test_rise();
        bus.raw_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            logic exp_ctl;
            logic exp_rise;
            tick();
            exp_ctl  = (i >= 6);
            exp_rise = (i == 6);
            checks++;
            if (bus.control !== exp_ctl || bus.control_rise !== exp_rise
                || bus.control_fall !== 1'b0 || bus.glitch_cnt !== 8'd0) begin
                failures++;
                $display("FAIL rise[%0d]: ctl=%b rise=%b fall=%b glitch=%0d required %b/%b/0/0",
                         i, bus.control, bus.control_rise, bus.control_fall, bus.glitch_cnt,
                         exp_ctl, exp_rise);
            end
        end
    endtask

    task automatic test_fall();
        bus.raw_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            logic exp_ctl;
            logic exp_fall;
            tick();
            exp_ctl  = (i < 6);
            exp_fall = (i == 6);
            checks++;
            if (bus.control !== exp_ctl || bus.control_fall !== exp_fall
                || bus.control_rise !== 1'b0 || bus.glitch_cnt !== 8'd0) begin
                failures++;
                $display("FAIL fall[%0d]: ctl=%b rise=%b fall=%b glitch=%0d required %b/0/%b/0",
                         i, bus.control, bus.control_rise, bus.control_fall, bus.glitch_cnt,
                         exp_ctl, exp_fall);
            end
        end
    endtask

    // Three high samples then low: abort lands at edge k+5 (i=6).
    task automatic test_glitch();
        for (int i = 1; i <= 10; i++) begin
            logic [7:0] exp_g;
            bus.raw_in = (i <= 3);
            tick();
            exp_g = (i >= 6) ? 8'd1 : 8'd0;
            checks++;
            if (bus.control !== 1'b0 || bus.control_rise !== 1'b0 || bus.control_fall !== 1'b0
                || bus.glitch_cnt !== exp_g) begin
                failures++;
                $display("FAIL glitch[%0d]: ctl=%b rise=%b fall=%b glitch=%0d required 0/0/0/%0d",
                         i, bus.control, bus.control_rise, bus.control_fall, bus.glitch_cnt, exp_g);
            end
        end
    endtask

    // 300 pulses of 2 high / 4 low, starting from glitch_cnt=1.
    task automatic test_saturate();
        for (int p = 1; p <= 300; p++) begin
            for (int t = 0; t < 6; t++) begin
                bus.raw_in = (t < 2);
                tick();
                checks++;
                if (bus.control !== 1'b0 || bus.control_rise !== 1'b0
                    || bus.control_fall !== 1'b0) begin
                    failures++;
                    $display("FAIL sat_quiet[%0d.%0d]: ctl=%b rise=%b fall=%b required 0/0/0",
                             p, t, bus.control, bus.control_rise, bus.control_fall);
                end
            end
            if (p == 100) begin
                checks++;
                if (bus.glitch_cnt !== 8'd101) begin
                    failures++;
                    $display("FAIL sat_mid: glitch=%0d required 101", bus.glitch_cnt);
                end
            end
        end
        for (int t = 0; t < 4; t++) tick();
        checks++;
        if (bus.glitch_cnt !== 8'd255) begin
            failures++;
            $display("FAIL sat_hold: glitch=%0d required 255", bus.glitch_cnt);
        end
    endtask

    // Reset lands one edge before the rise would have been accepted.
    task automatic test_reset_mid_wait();
        bus.raw_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (bus.control !== 1'b0 || bus.control_rise !== 1'b0) begin
            failures++;
            $display("FAIL rmw_pre: ctl=%b rise=%b required 0/0", bus.control, bus.control_rise);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (bus.control !== 1'b0 || bus.control_rise !== 1'b0 || bus.control_fall !== 1'b0
            || bus.glitch_cnt !== 8'd0) begin
            failures++;
            $display("FAIL rmw_reset: ctl=%b rise=%b fall=%b glitch=%0d required 0/0/0/0",
                     bus.control, bus.control_rise, bus.control_fall, bus.glitch_cnt);
        end
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            logic exp_ctl;
            logic exp_rise;
            tick();
            exp_ctl  = (i >= 6);
            exp_rise = (i == 6);
            checks++;
            if (bus.control !== exp_ctl || bus.control_rise !== exp_rise
                || bus.control_fall !== 1'b0 || bus.glitch_cnt !== 8'd0) begin
                failures++;
                $display("FAIL rmw_after[%0d]: ctl=%b rise=%b fall=%b glitch=%0d required %b/%b/0/0",
                         i, bus.control, bus.control_rise, bus.control_fall, bus.glitch_cnt,
                         exp_ctl, exp_rise);
            end
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        bus.raw_in = 1'b0;
        test_reset();
        test_rise();
        test_fall();
        test_glitch();
        test_saturate();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
